// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
// prog_counter : up/down counter with modulo, prescaler, load, one-shot mode
// Revision     : 1.0
// ============================================================================
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      modulo,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  oneshot,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic                  step;
  logic                  wrap;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pre_cnt_d = pre_cnt_q;
    tc_d      = 1'b0;
    done_d    = done_q;
    step      = 1'b0;
    wrap      = 1'b0;

    if (load) begin
      count_d   = load_val;
      pre_cnt_d = '0;
      done_d    = 1'b0;
      state_d   = ST_RUN;
    end else if (en && (state_q == ST_RUN)) begin
      step = (pre_cnt_q == prescale);
      if (step) begin
        pre_cnt_d = '0;
        // Up uses >= so an out-of-range loaded value wraps on the next step
        if (up) begin
          if (count_q >= modulo) begin
            count_d = '0;
            wrap    = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_d = modulo;
            wrap    = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        if (wrap) begin
          tc_d = 1'b1;
          if (oneshot) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      count_q   <= '0;
      pre_cnt_q <= '0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
      done_q    <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
// tb_prog_counter : directed + randomized check of prog_counter vs a model
// Revision        : 1.0
// ============================================================================
module tb_prog_counter;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic                  up;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      modulo;
  logic [PRESCALE_W-1:0] prescale;
  logic                  oneshot;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  done;

  int tests = 0;
  int fails = 0;
  int tc_seen = 0;

  // Reference state kept as plain integers
  int m_count = 0;
  int m_pre   = 0;
  int m_tc    = 0;
  int m_done  = 0;
  bit m_halt  = 1'b0;

  prog_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .modulo   (modulo),
    .prescale (prescale),
    .oneshot  (oneshot),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int mod_i;
    mod_i = int'(modulo);
    if (rst) begin
      m_count = 0; m_pre = 0; m_tc = 0; m_done = 0; m_halt = 1'b0;
    end else if (load) begin
      m_count = int'(load_val); m_pre = 0; m_tc = 0; m_done = 0; m_halt = 1'b0;
    end else begin
      m_tc = 0;
      if (en && !m_halt) begin
        if (m_pre == int'(prescale)) begin
          bit wrapped;
          m_pre   = 0;
          wrapped = 1'b0;
          if (up) begin
            if (m_count >= mod_i) begin m_count = 0; wrapped = 1'b1; end
            else m_count = m_count + 1;
          end else begin
            if (m_count == 0) begin m_count = mod_i; wrapped = 1'b1; end
            else m_count = m_count - 1;
          end
          if (wrapped) begin
            m_tc = 1;
            if (oneshot) begin m_halt = 1'b1; m_done = 1; end
          end
        end else begin
          m_pre = (m_pre + 1) % (1 << PRESCALE_W);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("count", 32'(count), 32'(m_count));
    check("tc",    32'(tc),    32'(m_tc));
    check("done",  32'(done),  32'(m_done));
    if (tc === 1'b1) tc_seen++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    modulo = 8'd255; prescale = '0; oneshot = 1'b0;

    // Reset state
    tick(); tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_done",  32'(done),  32'd0);

    // Free-running full range, one wrap
    rst = 1'b0; en = 1'b1; tc_seen = 0;
    repeat (255) tick();
    check("full_range_top", 32'(count), 32'd255);
    tick();
    check("full_range_wrap_tc", 32'(tc), 32'd1);
    repeat (4) tick();
    check("full_range_tc_once", 32'(tc_seen), 32'd1);

    // Modulo 9 with divide-by-3
    load = 1'b1; load_val = 8'd0; tick();
    load = 1'b0; modulo = 8'd9; prescale = 4'd2; tc_seen = 0;
    repeat (60) tick();
    check("mod9_pre2_tc_count", 32'(tc_seen), 32'd2);

    // Down count with load
    up = 1'b0; modulo = 8'd5; prescale = 4'd0;
    load = 1'b1; load_val = 8'd2; tick();
    check("down_load", 32'(count), 32'd2);
    load = 1'b0;
    repeat (3) tick();
    check("down_wrap_to_mod", 32'(count), 32'd5);
    check("down_wrap_tc", 32'(tc), 32'd1);
    tick();

    // One-shot halt, then reload
    up = 1'b1; oneshot = 1'b1; modulo = 8'd3;
    load = 1'b1; load_val = 8'd0; tick();
    load = 1'b0;
    repeat (4) tick();
    check("oneshot_done", 32'(done), 32'd1);
    oneshot = 1'b0;
    repeat (20) tick();
    check("oneshot_hold_count", 32'(count), 32'd0);
    check("oneshot_hold_done",  32'(done),  32'd1);
    oneshot = 1'b1;
    load = 1'b1; load_val = 8'd1; tick();
    check("oneshot_reload_done", 32'(done), 32'd0);
    load = 1'b0;
    repeat (2) tick();
    check("oneshot_resume", 32'(count), 32'd3);
    tick();

    // Load wins over a coincident step and clears the prescale phase
    oneshot = 1'b0; modulo = 8'd20; prescale = 4'd3;
    load = 1'b1; load_val = 8'd0; tick();
    load = 1'b0;
    repeat (3) tick();
    load = 1'b1; load_val = 8'd7; tick();
    load = 1'b0;
    repeat (3) tick();
    check("load_phase_hold", 32'(count), 32'd7);
    tick();
    check("load_phase_step", 32'(count), 32'd8);
    tick(); tick();
    rst = 1'b1; load = 1'b1; load_val = 8'd15; tick();
    check("rst_over_load", 32'(count), 32'd0);
    rst = 1'b0; load = 1'b0;

    // Out-of-range load wraps on next step; enable freeze keeps phase
    modulo = 8'd9; prescale = 4'd0;
    load = 1'b1; load_val = 8'd12; tick();
    load = 1'b0; tick();
    check("overrange_wrap", 32'(count), 32'd0);
    check("overrange_tc",   32'(tc),    32'd1);
    prescale = 4'd3;
    repeat (2) tick();
    en = 1'b0;
    repeat (5) tick();
    check("freeze_count", 32'(count), 32'd0);
    en = 1'b1;
    repeat (8) tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 31) == 0);
      load_val = WIDTH'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      if ($urandom_range(0, 63) == 0) modulo = WIDTH'($urandom_range(0, 40));
      if ($urandom_range(0, 31) == 0) prescale = PRESCALE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) oneshot = ~oneshot;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
